// File: rtl/present_decrypt_if.sv
// rtl/present_decrypt_if.sv - request/response bundle for the PRESENT-80 decryptor
interface present_decrypt_if;
  logic [79:0] master_key;
  logic [63:0] cipher_text;
  logic        start;
  logic [63:0] out;
  logic        ended;
  logic        busy;

  modport master (output master_key, cipher_text, start, input out, ended, busy);
  modport slave  (input master_key, cipher_text, start, output out, ended, busy);
endinterface

// File: rtl/present_decrypt.sv
// rtl/present_decrypt.sv - PRESENT-80 iterative decryptor
// Runs the key schedule forward to K32, then peels off rounds while stepping it back.
module present_decrypt (
  input  logic             clk,
  input  logic             rst,
  present_decrypt_if.slave bus
);
  typedef enum logic [2:0] {IDLE, KEYEXP, WHITEN, DECRYPT, DONE} state_t;

  state_t      state;
  logic [79:0] key_reg;
  logic [63:0] data_reg;
  logic [4:0]  cnt;
  logic [79:0] key_prev;
  logic [63:0] data_prev;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5; 4'h1: return 4'hE; 4'h2: return 4'hF; 4'h3: return 4'h8;
      4'h4: return 4'hC; 4'h5: return 4'h1; 4'h6: return 4'h2; 4'h7: return 4'hD;
      4'h8: return 4'hB; 4'h9: return 4'h4; 4'hA: return 4'h6; 4'hB: return 4'h3;
      4'hC: return 4'h0; 4'hD: return 4'h7; 4'hE: return 4'h9; default: return 4'hA;
    endcase
  endfunction

  // Forward pLayer moves bit i to 16*i mod 63, so the inverse reads from there.
  function automatic logic [63:0] inv_player(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 63; i++) r[i] = d[(16 * i) % 63];
    r[63] = d[63];
    return r;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] d);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox(d[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ i;
    return r;
  endfunction

  function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ i;
    r[79:76]   = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  assign key_prev  = inv_update(key_reg, cnt);
  assign data_prev = inv_sbox_layer(inv_player(data_reg)) ^ key_prev[79:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      data_reg  <= '0;
      cnt       <= '0;
      bus.out   <= '0;
      bus.ended <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            key_reg  <= bus.master_key;
            data_reg <= bus.cipher_text;
            cnt      <= 5'd1;
            bus.busy <= 1'b1;
            state    <= KEYEXP;
          end
        end
        KEYEXP: begin
          key_reg <= fwd_update(key_reg, cnt);
          if (cnt == 5'd31) state <= WHITEN;
          else              cnt   <= cnt + 5'd1;
        end
        WHITEN: begin
          data_reg <= data_reg ^ key_reg[79:16];
          state    <= DECRYPT;
        end
        DECRYPT: begin
          key_reg  <= key_prev;
          data_reg <= data_prev;
          if (cnt == 5'd1) begin
            bus.out   <= data_prev;
            bus.ended <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          // A held start must drop before another request is taken.
          if (!bus.start) begin
            bus.ended <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_present_decrypt.sv
// tb/tb_present_decrypt.sv - self-checking bench for present_decrypt
module tb_present_decrypt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  present_decrypt_if bus ();
  present_decrypt dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // Reference encryptor: full round-key table first, then 31 textbook rounds.
  function automatic logic [63:0] model_encrypt(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] rk [1:32];
    logic [79:0] k;
    logic [63:0] s, p;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = k[79:16];
      k = (k << 61) | (k >> 19);
      k[79:76] = SBOX[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ rk[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
      for (int b = 0; b < 63; b++) p[(16 * b) % 63] = s[b];
      p[63] = s[63];
      s = p;
    end
    return s ^ rk[32];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a request from IDLE, waits for ended and checks latency, busy and result.
  task automatic run_op(input logic [79:0] key, input logic [63:0] ct, input logic [63:0] exp,
                        input bit hold_start, input bit perturb, input string tag);
    int cycles = 0;
    int busy_drops = 0;
    bus.master_key  = key;
    bus.cipher_text = ct;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy_after_accept"}, 64'(bus.busy), 64'd1);
    if (!hold_start) bus.start = 1'b0;
    while (!bus.ended && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (perturb && cycles == 40) begin
        bus.master_key  = {16'($urandom), $urandom, $urandom};
        bus.cipher_text = {$urandom, $urandom};
      end
      if (!bus.ended && !bus.busy) busy_drops++;
    end
    check({tag, " latency"}, 64'(cycles), 64'd63);
    check({tag, " out"}, bus.out, exp);
    check({tag, " busy_drops"}, 64'(busy_drops), 64'd0);
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic release_op(input string tag);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check({tag, " ended_clear"}, 64'(bus.ended), 64'd0);
  endtask

  initial begin
    logic [79:0] key;
    logic [63:0] pt, ct, last;
    bus.master_key  = '0;
    bus.cipher_text = '0;
    bus.start       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out", bus.out, 64'd0);
    check("reset ended", 64'(bus.ended), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(80'h0, 64'h5579C1387B228445, 64'h0, 1'b1, 1'b0, "v1");
    release_op("v1");
    run_op(80'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, "v2a");
    release_op("v2a");
    run_op({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0, 1'b0, 1'b0, "v2b");
    release_op("v2b");
    run_op({80{1'b1}}, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, "v3_perturb");
    release_op("v3_perturb");

    ct = model_encrypt(80'h0, 64'h7777AAAA3333EEEE);
    run_op(80'h0, ct, 64'h7777AAAA3333EEEE, 1'b0, 1'b0, "loop1");
    release_op("loop1");
    ct = model_encrypt(80'h0123456789ABCDEF0123, 64'hBABABABABABABABA);
    run_op(80'h0123456789ABCDEF0123, ct, 64'hBABABABABABABABA, 1'b0, 1'b0, "loop2");
    release_op("loop2");

    for (int t = 0; t < 4; t++) begin
      key = {16'($urandom), $urandom, $urandom};
      pt  = {$urandom, $urandom};
      ct  = model_encrypt(key, pt);
      run_op(key, ct, pt, 1'b0, 1'b1, $sformatf("rand%0d", t));
      release_op($sformatf("rand%0d", t));
    end

    // Abort in DECRYPT around cnt=15.
    bus.master_key  = 80'h0;
    bus.cipher_text = 64'h5579C1387B228445;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort out", bus.out, 64'd0);
    check("abort ended", 64'(bus.ended), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    repeat (70) @(posedge clk);
    #1;
    check("abort no_late_ended", 64'(bus.ended), 64'd0);
    check("abort still_idle", 64'(bus.busy), 64'd0);

    // Reset and start together: reset wins, no busy.
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("rst_start busy", 64'(bus.busy), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;

    run_op(80'h0, 64'h5579C1387B228445, 64'h0, 1'b1, 1'b0, "restart");
    repeat (80) @(posedge clk);
    #1;
    check("hold ended", 64'(bus.ended), 64'd1);
    check("hold no_retrigger", 64'(bus.busy), 64'd0);
    last = bus.out;
    release_op("hold");
    check("hold out_kept", bus.out, last);
    run_op(80'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, "rerun");
    release_op("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
